id_ex_stage: RTL and testbench

//  ID/EX pipeline register of the 5-stage core, directly downstream of RegFile. Captures the

---
 rtl/id_ex_stage_if.sv | 43 ++++
 rtl/id_ex_stage.sv | 94 +++++++++
 tb/tb_id_ex_stage.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID->EX handoff bundle: ID-side decode, WB bypass and flush inputs, plus registered EX-side outputs.
// master drives ID/WB/flush and observes the stage; slave is the pipeline register itself.
interface id_ex_stage_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
);
    logic               id_valid;
    logic [RADDR_W-1:0] id_rs;
    logic [RADDR_W-1:0] id_rt;
    logic [RADDR_W-1:0] id_rd;
    logic               id_uses_rt;
    logic [DATA_W-1:0]  id_rdata1;
    logic [DATA_W-1:0]  id_rdata2;
    logic [DATA_W-1:0]  id_imm;
    logic [7:0]         id_ctrl;
    logic               wb_regwrite;
    logic [RADDR_W-1:0] wb_writereg;
    logic [DATA_W-1:0]  wb_writedata;
    logic               ex_flush;
    logic               stall;
    logic               ex_valid;
    logic [RADDR_W-1:0] ex_rs;
    logic [RADDR_W-1:0] ex_rt;
    logic [RADDR_W-1:0] ex_rd;
    logic [DATA_W-1:0]  ex_a;
    logic [DATA_W-1:0]  ex_b;
    logic [DATA_W-1:0]  ex_imm;
    logic [7:0]         ex_ctrl;
    logic [CNT_W-1:0]   bubble_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_rdata1, id_rdata2, id_imm, id_ctrl,
        output wb_regwrite, wb_writereg, wb_writedata, ex_flush,
        input  stall, ex_valid, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm, ex_ctrl, bubble_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_rdata1, id_rdata2, id_imm, id_ctrl,
        input  wb_regwrite, wb_writereg, wb_writedata, ex_flush,
        output stall, ex_valid, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm, ex_ctrl, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall/bubble, WB->operand bypass and EX flush; 1-cycle latency.
// Upstream holds ID while stall is high (combinational, one cycle per load); flush overrides stall.
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);
    logic               ex_valid_q, ex_valid_d;
    logic [RADDR_W-1:0] ex_rs_q, ex_rs_d;
    logic [RADDR_W-1:0] ex_rt_q, ex_rt_d;
    logic [RADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic [DATA_W-1:0]  ex_a_q, ex_a_d;
    logic [DATA_W-1:0]  ex_b_q, ex_b_d;
    logic [DATA_W-1:0]  ex_imm_q, ex_imm_d;
    logic [7:0]         ex_ctrl_q, ex_ctrl_d;
    logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;
    logic               hazard;
    logic               bypass_a;
    logic               bypass_b;

    // ex_ctrl_q[6] is memread: a load in EX whose rt is still needed by ID
    assign hazard = ex_valid_q & ex_ctrl_q[6] & (ex_rt_q != '0) & bus.id_valid &
                    ((ex_rt_q == bus.id_rs) | (bus.id_uses_rt & (ex_rt_q == bus.id_rt)));

    assign bypass_a = bus.wb_regwrite & (bus.wb_writereg != '0) & (bus.wb_writereg == bus.id_rs);
    assign bypass_b = bus.wb_regwrite & (bus.wb_writereg != '0) & (bus.wb_writereg == bus.id_rt);

    always_comb begin
        ex_valid_d   = 1'b0;
        ex_rs_d      = '0;
        ex_rt_d      = '0;
        ex_rd_d      = '0;
        ex_a_d       = '0;
        ex_b_d       = '0;
        ex_imm_d     = '0;
        ex_ctrl_d    = '0;
        bubble_cnt_d = bubble_cnt_q;
        if (bus.ex_flush) begin
            bubble_cnt_d = bubble_cnt_q;
        end else if (hazard) begin
            if (!(&bubble_cnt_q)) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end else begin
            ex_valid_d = bus.id_valid;
            ex_ctrl_d  = bus.id_valid ? bus.id_ctrl : 8'h00;
            ex_rs_d    = bus.id_rs;
            ex_rt_d    = bus.id_rt;
            ex_rd_d    = bus.id_rd;
            ex_imm_d   = bus.id_imm;
            ex_a_d     = bypass_a ? bus.wb_writedata : bus.id_rdata1;
            ex_b_d     = bypass_b ? bus.wb_writedata : bus.id_rdata2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            ex_a_q       <= '0;
            ex_b_q       <= '0;
            ex_imm_q     <= '0;
            ex_ctrl_q    <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            ex_a_q       <= ex_a_d;
            ex_b_q       <= ex_b_d;
            ex_imm_q     <= ex_imm_d;
            ex_ctrl_q    <= ex_ctrl_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.stall      = hazard & ~bus.ex_flush;
    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_rs      = ex_rs_q;
    assign bus.ex_rt      = ex_rt_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.ex_a       = ex_a_q;
    assign bus.ex_b       = ex_b_q;
    assign bus.ex_imm     = ex_imm_q;
    assign bus.ex_ctrl    = ex_ctrl_q;
    assign bus.bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, load-use stall, r0 exemption, bypass, flush, saturation.
module tb_id_ex_stage;
    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int CNT_W   = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    id_ex_stage_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic vld, input logic [7:0] ctrl, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic uses_rt,
                          input logic [31:0] rd1, input logic [31:0] rd2);
        bus.id_valid   = vld;
        bus.id_ctrl    = ctrl;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_rd      = rd;
        bus.id_uses_rt = uses_rt;
        bus.id_rdata1  = rd1;
        bus.id_rdata2  = rd2;
        bus.id_imm     = 32'h0000_0010;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        // Random inputs while reset is held
        set_id($urandom, 8'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom,
               $urandom, $urandom);
        bus.wb_regwrite  = $urandom;
        bus.wb_writereg  = 5'($urandom);
        bus.wb_writedata = $urandom;
        bus.ex_flush     = $urandom;
        #3;
        @(posedge clk);
        #1;
        check("rst_ex_valid", bus.ex_valid, 0);
        check("rst_ex_ctrl", bus.ex_ctrl, 0);
        check("rst_ex_a", bus.ex_a, 0);
        check("rst_ex_b", bus.ex_b, 0);
        check("rst_ex_rd", bus.ex_rd, 0);
        check("rst_ex_imm", bus.ex_imm, 0);
        check("rst_bubble_cnt", bus.bubble_cnt, 0);
        check("rst_stall", bus.stall, 0);
        rst_n = 1'b1;
        bus.wb_regwrite = 1'b0;
        bus.wb_writereg = '0;
        bus.ex_flush    = 1'b0;

        // Basic capture
        set_id(1, 8'h80, 3, 0, 4, 0, 32'h150, 32'h0);
        step();
        check("cap_ex_valid", bus.ex_valid, 1);
        check("cap_ex_ctrl", bus.ex_ctrl, 8'h80);
        check("cap_ex_a", bus.ex_a, 32'h150);
        check("cap_ex_rd", bus.ex_rd, 4);
        check("cap_ex_imm", bus.ex_imm, 32'h10);

        // Load-use: lw rt=3 then add rs=3
        set_id(1, 8'hD8, 1, 3, 0, 0, 32'h1, 32'h2);
        step();
        check("lw_ex_ctrl", bus.ex_ctrl, 8'hD8);
        check("lw_ex_rt", bus.ex_rt, 3);
        set_id(1, 8'h86, 3, 2, 5, 1, 32'haa, 32'hbb);
        #1;
        check("lu_stall", bus.stall, 1);
        step();
        check("lu_bub_valid", bus.ex_valid, 0);
        check("lu_bub_ctrl", bus.ex_ctrl, 0);
        check("lu_bub_a", bus.ex_a, 0);
        check("lu_bubble_cnt", bus.bubble_cnt, 1);
        check("lu_stall_clear", bus.stall, 0);
        step();
        check("lu_add_valid", bus.ex_valid, 1);
        check("lu_add_ctrl", bus.ex_ctrl, 8'h86);
        check("lu_add_rd", bus.ex_rd, 5);
        check("lu_add_a", bus.ex_a, 32'haa);
        check("lu_cnt_hold", bus.bubble_cnt, 1);

        // r0 exemption and id_uses_rt gating
        set_id(1, 8'hD8, 1, 0, 0, 0, 32'h1, 32'h2);
        step();
        set_id(1, 8'h86, 0, 0, 6, 1, 32'h1, 32'h2);
        #1;
        check("r0_no_stall", bus.stall, 0);
        set_id(1, 8'hD8, 1, 7, 0, 0, 32'h1, 32'h2);
        step();
        check("lw7_ex_rt", bus.ex_rt, 7);
        set_id(1, 8'h86, 1, 7, 6, 0, 32'h1, 32'h2);
        #1;
        check("no_uses_rt_stall", bus.stall, 0);
        bus.id_uses_rt = 1'b1;
        #1;
        check("uses_rt_stall", bus.stall, 1);

        // Flush beats hazard
        bus.ex_flush = 1'b1;
        #1;
        check("flush_stall", bus.stall, 0);
        step();
        check("flush_valid", bus.ex_valid, 0);
        check("flush_ctrl", bus.ex_ctrl, 0);
        check("flush_cnt", bus.bubble_cnt, 1);
        bus.ex_flush = 1'b0;

        // WB bypass
        set_id(1, 8'h86, 2, 4, 6, 1, 32'h11, 32'hff);
        bus.wb_regwrite  = 1'b1;
        bus.wb_writereg  = 4;
        bus.wb_writedata = 32'h66;
        step();
        check("byp_b", bus.ex_b, 32'h66);
        check("byp_a_none", bus.ex_a, 32'h11);
        bus.wb_writereg = 2;
        step();
        check("byp_a", bus.ex_a, 32'h66);
        check("byp_b_none", bus.ex_b, 32'hff);
        set_id(1, 8'h86, 0, 0, 6, 1, 32'h22, 32'h33);
        bus.wb_writereg  = 0;
        bus.wb_writedata = 32'h77;
        step();
        check("byp_r0_a", bus.ex_a, 32'h22);
        check("byp_r0_b", bus.ex_b, 32'h33);
        set_id(1, 8'h86, 2, 4, 6, 1, 32'h44, 32'h55);
        bus.wb_regwrite = 1'b0;
        bus.wb_writereg = 2;
        step();
        check("byp_no_we_a", bus.ex_a, 32'h44);

        // Invalid ID: ctrl forced to 0
        set_id(0, 8'hff, 1, 2, 3, 0, 32'h1, 32'h2);
        step();
        check("inv_valid", bus.ex_valid, 0);
        check("inv_ctrl", bus.ex_ctrl, 0);

        // Saturation: one bubble per lw/add pair, 20 pairs starting from count 1
        for (int i = 0; i < 20; i++) begin
            set_id(1, 8'hD8, 1, 5, 0, 0, 32'h1, 32'h2);
            step();
            set_id(1, 8'h86, 5, 2, 6, 1, 32'h1, 32'h2);
            step();
        end
        check("sat_cnt", bus.bubble_cnt, 4'hF);
        set_id(1, 8'hD8, 1, 5, 0, 0, 32'h1, 32'h2);
        step();
        set_id(1, 8'h86, 5, 2, 6, 1, 32'h1, 32'h2);
        step();
        check("sat_hold", bus.bubble_cnt, 4'hF);

        // Asynchronous reset mid-cycle
        set_id(1, 8'h80, 3, 0, 4, 0, 32'h150, 32'h0);
        step();
        check("pre_arst_valid", bus.ex_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cnt", bus.bubble_cnt, 0);
        check("arst_valid", bus.ex_valid, 0);
        check("arst_ctrl", bus.ex_ctrl, 0);
        check("arst_a", bus.ex_a, 0);
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
